// File: rtl/uart_tx_flow.sv
// 8N1 UART transmitter merging a one-deep control byte buffer with a payload FIFO.
// Pending control bytes always win arbitration over payload in the idle state.
module uart_tx_flow #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ctl_msg,
  input  logic       ctl_wr,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       ctl_pending,
  output logic       ctl_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_cnt_next;
  logic [15:0] r_baud_cnt;
  logic [15:0] w_baud_cnt_next;
  logic        r_tx;
  logic        w_tx_next;
  logic [7:0]  r_ctl_msg;
  logic        r_ctl_pending;
  logic        r_ctl_ovf;
  logic        w_baud_tick;
  logic        w_ctl_consume;
  logic        w_data_take;

  assign w_baud_tick   = (r_baud_cnt == BAUD_LAST);
  assign w_ctl_consume = (r_state == IDLE) && r_ctl_pending;
  assign data_ready    = (r_state == IDLE) && !r_ctl_pending && !rst;
  assign w_data_take   = data_ready && data_valid;

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_baud_cnt_next = r_baud_cnt;
    case (r_state)
      IDLE: begin
        w_baud_cnt_next = 16'd0;
        w_bit_cnt_next  = 3'd0;
        if (w_ctl_consume) begin
          w_state_next = START;
          w_shift_next = r_ctl_msg;
        end else if (w_data_take) begin
          w_state_next = START;
          w_shift_next = data_in;
        end
      end
      START: begin
        if (w_baud_tick) begin
          w_state_next    = DATA;
          w_baud_cnt_next = 16'd0;
          w_bit_cnt_next  = 3'd0;
        end else begin
          w_baud_cnt_next = r_baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (w_baud_tick) begin
          w_baud_cnt_next = 16'd0;
          w_shift_next    = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (w_baud_tick) begin
          w_state_next    = IDLE;
          w_baud_cnt_next = 16'd0;
        end else begin
          w_baud_cnt_next = r_baud_cnt + 16'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // tx is registered from the next state so the line moves in the same cycle as the state
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_baud_cnt <= 16'd0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_tx       <= w_tx_next;
    end
  end

  // Latest flow-control byte wins; overwrite of an unconsumed byte is flagged sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl_msg     <= 8'h00;
      r_ctl_pending <= 1'b0;
      r_ctl_ovf     <= 1'b0;
    end else if (ctl_wr) begin
      r_ctl_msg     <= ctl_msg;
      r_ctl_pending <= 1'b1;
      if (r_ctl_pending && !w_ctl_consume) begin
        r_ctl_ovf <= 1'b1;
      end
    end else if (w_ctl_consume) begin
      r_ctl_pending <= 1'b0;
    end
  end

  assign tx          = r_tx;
  assign busy        = (r_state != IDLE);
  assign ctl_pending = r_ctl_pending;
  assign ctl_ovf     = r_ctl_ovf;

endmodule

// File: tb/tb_uart_tx_flow.sv
// Bench for uart_tx_flow: frame-timing model compared every cycle, plus a line
// decoder whose captured bytes are checked against hand-computed lists.
module tb_uart_tx_flow;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ctl_msg;
  logic       ctl_wr;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       ctl_pending;
  logic       ctl_ovf;

  uart_tx_flow #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .ctl_msg(ctl_msg), .ctl_wr(ctl_wr),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .tx(tx), .busy(busy), .ctl_pending(ctl_pending), .ctl_ovf(ctl_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  // model: a frame is a byte plus elapsed cycles since acceptance
  bit         m_active = 0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_pend = 0;
  logic [7:0] m_cmsg = 8'h00;
  bit         m_ovf = 0;

  logic [7:0] fifo[$];
  bit         pop_flag = 0;

  logic [7:0] rx_bytes[$];
  int         fall_times[$];
  bit         rx_busy = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  int         frame_err = 0;
  int         ready_pulses = 0;
  int         busy_cycles = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = (m_t - 1) / B;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit consume;
    cyc++;
    if (rst) begin
      m_active = 0;
      m_pend   = 0;
      m_ovf    = 0;
    end else begin
      consume = !m_active && m_pend;
      if (m_active) begin
        if (m_t == 10 * B) m_active = 0;
        else m_t++;
      end else if (consume) begin
        m_active = 1; m_t = 1; m_byte = m_cmsg;
      end else if (data_valid) begin
        m_active = 1; m_t = 1; m_byte = data_in;
      end
      if (ctl_wr) begin
        if (m_pend && !consume) m_ovf = 1;
        m_cmsg = ctl_msg;
        m_pend = 1;
      end else if (consume) begin
        m_pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", tx, exp_tx());
      chk("busy", busy, m_active);
      chk("data_ready", data_ready, !m_active && !m_pend && !rst);
      chk("ctl_pending", ctl_pending, m_pend);
      chk("ctl_ovf", ctl_ovf, m_ovf);
    end
    pop_flag = (data_ready === 1'b1) && data_valid;
    if (pop_flag) ready_pulses++;
    if (busy === 1'b1) busy_cycles++;
    if (rst) begin
      rx_busy = 0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy = 1; rx_cnt = 0; fall_times.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == B / 2 && tx !== 1'b0) frame_err++;
      if (rx_cnt % B == B / 2 && rx_cnt / B >= 1 && rx_cnt / B <= 8)
        rx_sh[rx_cnt/B-1] = tx;
      if (rx_cnt == 9 * B + B / 2) begin
        if (tx !== 1'b1) frame_err++;
        rx_bytes.push_back(rx_sh);
        rx_busy = 0;
      end
    end
  end

  function automatic void refresh();
    data_valid = (fifo.size() > 0);
    data_in    = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endfunction

  always @(posedge clk) begin
    #1;
    if (pop_flag && fifo.size() > 0) fifo.delete(0);
    refresh();
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  task automatic ctl(input logic [7:0] b);
    ctl_msg = b; ctl_wr = 1'b1;
    tick(1);
    ctl_wr = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 100) begin
      tick(1); n++;
    end
    chk(name, busy, 1'b1);
  endtask

  task automatic clear_logs();
    rx_bytes.delete(); fall_times.delete();
    ready_pulses = 0; busy_cycles = 0; frame_err = 0;
  endtask

  // expected bytes packed with the first transmitted byte in the low bits
  task automatic check_rx(input string name, input int n, input logic [23:0] exp);
    logic [7:0] e;
    chk_int({name, "_count"}, rx_bytes.size(), n);
    for (int i = 0; i < n; i++) begin
      e = exp[8*i +: 8];
      if (i < rx_bytes.size()) chk_int({name, "_byte"}, int'(rx_bytes[i]), int'(e));
    end
    chk_int({name, "_framing"}, frame_err, 0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1; ctl_msg = 8'h00; ctl_wr = 1'b0; data_in = 8'h00; data_valid = 1'b0;
    tick(1);
    chk_en = 1;
    tick(2);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", data_ready, 1'b0);
    rst = 1'b0;

    // single payload byte 0xA5
    clear_logs();
    push(8'hA5);
    tick(50);
    check_rx("t1", 1, 24'h0000A5);
    chk_int("t1_ready_pulses", ready_pulses, 1);
    chk_int("t1_busy_cycles", busy_cycles, 40);
    $display("t1 single byte: rx=%0d bytes pulses=%0d busy=%0d", rx_bytes.size(), ready_pulses, busy_cycles);

    // three back-to-back payload bytes
    clear_logs();
    push(8'h01); push(8'h02); push(8'h03);
    tick(133);
    check_rx("t2", 3, 24'h030201);
    chk_int("t2_ready_pulses", ready_pulses, 3);
    if (fall_times.size() >= 3) begin
      chk_int("t2_period_a", fall_times[1] - fall_times[0], 10 * B + 1);
      chk_int("t2_period_b", fall_times[2] - fall_times[1], 10 * B + 1);
    end
    $display("t2 three bytes: rx=%0d bytes pulses=%0d", rx_bytes.size(), ready_pulses);

    // control byte preempts queued payload
    clear_logs();
    push(8'h10); push(8'h11);
    wait_busy("t3_wait_busy");
    tick(10);
    ctl(8'hFF);
    tick(133);
    check_rx("t3", 3, 24'h11FF10);
    chk_int("t3_ready_pulses", ready_pulses, 2);
    chk("t3_ovf", ctl_ovf, 1'b0);
    $display("t3 ctl preempt: rx=%0d bytes", rx_bytes.size());

    // overwrite of pending control byte
    clear_logs();
    push(8'h22);
    wait_busy("t4_wait_busy");
    tick(5);
    ctl(8'hFF);
    tick(5);
    ctl(8'hFE);
    tick(92);
    check_rx("t4", 2, 24'h00FE22);
    chk("t4_ovf", ctl_ovf, 1'b1);
    tick(20);
    chk("t4_ovf_held", ctl_ovf, 1'b1);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    chk("t4_ovf_cleared", ctl_ovf, 1'b0);
    $display("t4 overwrite: rx=%0d bytes", rx_bytes.size());

    // write in the same cycle the pending byte is consumed
    clear_logs();
    ctl_msg = 8'hFF; ctl_wr = 1'b1;
    tick(1);
    ctl_msg = 8'hFE;
    tick(1);
    ctl_wr = 1'b0;
    tick(92);
    check_rx("t5", 2, 24'h00FEFF);
    chk("t5_ovf", ctl_ovf, 1'b0);
    chk_int("t5_ready_pulses", ready_pulses, 0);
    $display("t5 consume+write: rx=%0d bytes", rx_bytes.size());

    // reset during data bit 3 discards frame and pending control byte
    clear_logs();
    push(8'h5A);
    wait_busy("t6_wait_busy");
    ctl(8'h77);
    tick(15);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t6_tx_after_rst", tx, 1'b1);
    chk("t6_busy_after_rst", busy, 1'b0);
    chk("t6_pending_after_rst", ctl_pending, 1'b0);
    clear_logs();
    push(8'hC3);
    tick(50);
    check_rx("t6", 1, 24'h0000C3);
    chk_int("t6_ready_pulses", ready_pulses, 1);
    $display("t6 reset abort: rx=%0d bytes", rx_bytes.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
